// File: rtl/difficulty_pkg.sv
// Shared types and level-to-parameter mappings for the difficulty ticker.
package difficulty_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   // Compared as a sum so a large lvl*step never wraps below the floor.
   function automatic int period_of(int lvl, int base, int step, int min_p);
      if (lvl * step + min_p >= base) return min_p;
      return base - lvl * step;
   endfunction

   function automatic int nums_of(int lvl, int max_n);
      return (lvl + 1 > max_n) ? max_n : lvl + 1;
   endfunction

   function automatic int clamp_lvl(int req, int levels);
      return (req > levels - 1) ? levels - 1 : req;
   endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running period counter: counts 0..period-1 while enabled, pulses tick on wrap.
module tick_counter #(
   parameter int CNT_W = 29
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] period,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (clr) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (en) begin
         // >= so a period shortened while paused still wraps instead of running away
         if (count >= period - CNT_W'(1)) begin
            count <= '0;
            tick  <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/difficulty_ticker.sv
// Game pacing ticker: run/pause/idle control, per-level period and target count,
// manual level loads and hit-driven auto-escalation applied at period boundaries.
module difficulty_ticker
   import difficulty_pkg::*;
#(
   parameter int LEVELS         = 4,
   parameter int CNT_W          = 29,
   parameter int NUM_W          = 3,
   parameter int BASE_PERIOD    = 60000000,
   parameter int STEP_PERIOD    = 15000000,
   parameter int MIN_PERIOD     = 30000000,
   parameter int MAX_NUMS       = 3,
   parameter int HITS_PER_LEVEL = 8,
   localparam int LW            = $clog2(LEVELS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   input  logic             diff_load,
   input  logic [LW-1:0]    diff_req,
   input  logic             hit,
   input  logic             auto_en,
   output logic             tick,
   output logic [LW-1:0]    level,
   output logic [CNT_W-1:0] size,
   output logic [NUM_W-1:0] nums,
   output logic             running
);

   localparam int HW = $clog2(HITS_PER_LEVEL + 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [HW-1:0]    hit_cnt;
   logic             pend_v;
   logic [LW-1:0]    pend_lvl;

   logic             in_run, cnt_en, cnt_clr, wrap;
   logic             esc_hit, esc_full, load;
   logic [LW-1:0]    req_lvl, up_lvl, load_lvl;

   always_comb begin
      in_run   = (state == S_RUN);
      cnt_en   = in_run && !pause && !stop;
      cnt_clr  = (state == S_IDLE) || stop;
      wrap     = cnt_en && (count >= size - CNT_W'(1));
      req_lvl  = LW'(clamp_lvl(int'(diff_req), LEVELS));
      up_lvl   = (level == LW'(LEVELS - 1)) ? level : level + LW'(1);
      esc_hit  = in_run && auto_en && hit && !stop;
      esc_full = esc_hit && (int'(hit_cnt) + 1 == HITS_PER_LEVEL);
      // Outside RUN (or when stopping) a load is immediate; in RUN it waits for the wrap.
      load     = 1'b0;
      load_lvl = level;
      if (diff_load && (!in_run || stop)) begin
         load     = 1'b1;
         load_lvl = req_lvl;
      end else if (wrap && pend_v) begin
         load     = 1'b1;
         load_lvl = pend_lvl;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         running  <= 1'b0;
         hit_cnt  <= '0;
         pend_v   <= 1'b0;
         pend_lvl <= '0;
         level    <= '0;
         size     <= CNT_W'(period_of(0, BASE_PERIOD, STEP_PERIOD, MIN_PERIOD));
         nums     <= NUM_W'(nums_of(0, MAX_NUMS));
      end else begin
         if (stop) begin
            state   <= S_IDLE;
            running <= 1'b0;
         end else if (pause) begin
            if (in_run) begin
               state   <= S_PAUSE;
               running <= 1'b0;
            end
         end else if (start && !in_run) begin
            state   <= S_RUN;
            running <= 1'b1;
         end

         if (stop || esc_full) hit_cnt <= '0;
         else if (esc_hit)     hit_cnt <= hit_cnt + HW'(1);

         // A pending level written on a wrap edge is held for the following wrap.
         if (stop || (diff_load && !in_run)) begin
            pend_v <= 1'b0;
         end else if (diff_load) begin
            pend_v   <= 1'b1;
            pend_lvl <= req_lvl;
         end else if (esc_full) begin
            pend_v   <= 1'b1;
            pend_lvl <= up_lvl;
         end else if (wrap) begin
            pend_v <= 1'b0;
         end

         if (load) begin
            level <= load_lvl;
            size  <= CNT_W'(period_of(int'(load_lvl), BASE_PERIOD, STEP_PERIOD, MIN_PERIOD));
            nums  <= NUM_W'(nums_of(int'(load_lvl), MAX_NUMS));
         end
      end
   end

   tick_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .en     (cnt_en),
      .clr    (cnt_clr),
      .period (size),
      .tick   (tick),
      .count  (count)
   );

endmodule

// File: tb/tb_difficulty_ticker.sv
// Bench for difficulty_ticker: directed scenarios plus random control traffic,
// all outputs compared every cycle against a rule-level reference model.
module tb_difficulty_ticker;

   localparam int LEVELS = 4;
   localparam int CNT_W  = 8;
   localparam int NUM_W  = 3;
   localparam int BASE   = 10;
   localparam int STEP   = 3;
   localparam int MINP   = 4;
   localparam int MAXN   = 3;
   localparam int HITS   = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

   logic clk = 0, reset = 1;
   logic start = 0, pause = 0, stop = 0, diff_load = 0, hit = 0, auto_en = 0;
   logic [1:0] diff_req = 0;
   logic [2:0] diff_req6 = 0;
   logic tick, running, tick6, running6;
   logic [1:0] level;
   logic [2:0] level6;
   logic [CNT_W-1:0] size, size6;
   logic [NUM_W-1:0] nums, nums6;

   int checks = 0, errors = 0;

   // model state: mode, position within period, hit tally, pending level (-1 none)
   int m_mode, m_pos, m_hits, m_pend, m_lvl, m_tick;

   always #5 clk = ~clk;

   difficulty_ticker #(.LEVELS(LEVELS), .CNT_W(CNT_W), .NUM_W(NUM_W), .BASE_PERIOD(BASE),
      .STEP_PERIOD(STEP), .MIN_PERIOD(MINP), .MAX_NUMS(MAXN), .HITS_PER_LEVEL(HITS)) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
      .diff_load(diff_load), .diff_req(diff_req), .hit(hit), .auto_en(auto_en),
      .tick(tick), .level(level), .size(size), .nums(nums), .running(running));

   difficulty_ticker #(.LEVELS(6), .CNT_W(CNT_W), .NUM_W(NUM_W), .BASE_PERIOD(BASE),
      .STEP_PERIOD(STEP), .MIN_PERIOD(MINP), .MAX_NUMS(MAXN), .HITS_PER_LEVEL(HITS)) dut6 (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
      .diff_load(diff_load), .diff_req(diff_req6), .hit(hit), .auto_en(auto_en),
      .tick(tick6), .level(level6), .size(size6), .nums(nums6), .running(running6));

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int per_m(int l);
      int p = BASE - l * STEP;
      return (p < MINP) ? MINP : p;
   endfunction

   function automatic int nums_m(int l);
      return (l + 1 < MAXN) ? l + 1 : MAXN;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_pos = 0; m_hits = 0; m_pend = -1; m_lvl = 0; m_tick = 0;
   endtask

   // One clock edge of the behavioural rules, using the inputs present at the edge.
   task automatic model_edge();
      int  req     = (int'(diff_req) > LEVELS - 1) ? LEVELS - 1 : int'(diff_req);
      int  old_lvl = m_lvl;
      int  old_pnd = m_pend;
      bit  was_run = (m_mode == M_RUN);
      bit  counting = was_run && !pause && !stop;
      bit  ends    = counting && (m_pos >= per_m(old_lvl) - 1);
      bit  esc     = 0;
      m_tick = ends;
      if (m_mode == M_IDLE || stop) m_pos = 0;
      else if (counting)            m_pos = ends ? 0 : m_pos + 1;
      if (stop) m_hits = 0;
      else if (was_run && auto_en && hit) begin
         m_hits++;
         if (m_hits == HITS) begin m_hits = 0; esc = 1; end
      end
      if (diff_load && (!was_run || stop)) m_lvl = req;
      else if (ends && old_pnd >= 0)       m_lvl = old_pnd;
      if (stop || (diff_load && !was_run)) m_pend = -1;
      else if (diff_load)                  m_pend = req;
      else if (esc)                        m_pend = (old_lvl + 1 > LEVELS - 1) ? LEVELS - 1 : old_lvl + 1;
      else if (ends)                       m_pend = -1;
      if (stop)                            m_mode = M_IDLE;
      else if (pause) begin if (was_run)   m_mode = M_PAUSE; end
      else if (start && !was_run)          m_mode = M_RUN;
   endtask

   task automatic check_all();
      chk("tick", tick, m_tick);
      chk("level", level, m_lvl);
      chk("size", size, per_m(m_lvl));
      chk("nums", nums, nums_m(m_lvl));
      chk("running", running, m_mode == M_RUN);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) model_reset(); else model_edge();
      #1;
      check_all();
   endtask

   initial begin
      logic [2:0] seven = 3'd7;
      model_reset();
      cycle(); cycle();
      chk("rst_size", size, 10); chk("rst_nums", nums, 1); chk("rst_run", running, 0);
      reset = 0;
      cycle();

      // basic periodic ticks at level 0
      start = 1; cycle(); start = 0;
      for (int k = 1; k <= 30; k++) begin
         cycle();
         chk("t031_tick", tick, (k % 10 == 0));
      end
      // manual load mid-period is deferred to the wrap
      diff_req = 2'd3;
      for (int k = 31; k <= 44; k++) begin
         diff_load = (k == 36);
         cycle();
         diff_load = 0;
         chk("t032_tick", tick, (k == 40 || k == 44));
         chk("t032_lvl", level, (k >= 40) ? 3 : 0);
      end
      chk("t032_size", size, 4); chk("t032_nums", nums, 3);

      // auto-escalation across successive wraps, then saturation
      stop = 1; cycle(); stop = 0;
      diff_req = 0; diff_load = 1; cycle(); diff_load = 0;
      auto_en = 1; start = 1; cycle(); start = 0;
      for (int k = 1; k <= 26; k++) begin
         hit = (k == 2 || k == 4 || k == 12 || k == 14 || k == 18 || k == 19 || k == 22 || k == 23);
         cycle();
         hit = 0;
         case (k)
            9:  chk("t033_l0", level, 0);
            10: begin chk("t033_l1", level, 1); chk("t033_s1", size, 7); chk("t033_n1", nums, 2); end
            17: begin chk("t033_l2", level, 2); chk("t033_s2", size, 4); chk("t033_n2", nums, 3); end
            21: chk("t033_l3", level, 3);
            25: chk("t033_sat", level, 3);
            default: ;
         endcase
      end
      auto_en = 0;

      // pause holds the count; resume continues from it
      stop = 1; cycle(); stop = 0;
      diff_req = 0; diff_load = 1; cycle(); diff_load = 0;
      start = 1; cycle(); start = 0;
      repeat (6) cycle();
      pause = 1; cycle(); pause = 0;
      for (int j = 0; j < 20; j++) begin
         cycle();
         chk("t034_ptick", tick, 0);
      end
      start = 1; cycle(); start = 0;
      for (int j = 1; j <= 5; j++) begin
         cycle();
         chk("t034_tick", tick, (j == 4));
      end

      // simultaneous controls: stop wins; out-of-range request clamps
      stop = 1; pause = 1; start = 1; cycle(); stop = 0; pause = 0; start = 0;
      chk("t035_run", running, 0);
      for (int j = 0; j < 12; j++) begin cycle(); chk("t035_idle_tick", tick, 0); end
      diff_req = seven[1:0]; diff_req6 = seven; diff_load = 1; cycle(); diff_load = 0;
      chk("t035_lvl", level, 3);
      chk("t035_lvl6", level6, 5); chk("t035_size6", size6, 4); chk("t035_nums6", nums6, 3);

      // asynchronous reset mid-period
      diff_req = 0; diff_req6 = 0; diff_load = 1; cycle(); diff_load = 0;
      start = 1; cycle(); start = 0;
      repeat (8) cycle();
      #3 reset = 1;
      #1 model_reset();
      chk("t036_tick", tick, 0); chk("t036_lvl", level, 0); chk("t036_size", size, 10);
      chk("t036_nums", nums, 1); chk("t036_run", running, 0);
      cycle(); cycle();
      reset = 0;
      for (int j = 0; j < 50; j++) begin cycle(); chk("t036_notick", tick, 0); end

      // random control traffic
      for (int j = 0; j < 1500; j++) begin
         start     = ($urandom_range(0, 15) == 0);
         pause     = ($urandom_range(0, 23) == 0);
         stop      = ($urandom_range(0, 63) == 0);
         diff_load = ($urandom_range(0, 19) == 0);
         diff_req  = 2'($urandom_range(0, 3));
         diff_req6 = 3'($urandom_range(0, 7));
         hit       = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
         reset     = ($urandom_range(0, 499) == 0);
         cycle();
      end
      reset = 0; start = 0; pause = 0; stop = 0; diff_load = 0; hit = 0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
